// File: rtl/bram_port_arbiter.sv
// Two-port arbiter in front of the single work-RAM port: latches CPU (A) and DMA (B)
// strobes, serves one access at a time and force-completes accesses that never finish.
module bram_port_arbiter #(
    parameter int AW       = 15,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 255,
    parameter int CPU_PRIO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_start,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    output logic          a_rdy,
    input  logic          b_start,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          b_rdy,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    output logic          m_we,
    output logic          m_start_read,
    input  logic          m_read_rdy,
    input  logic          m_save_rdy,
    input  logic [DW-1:0] m_dout,
    output logic          busy,
    output logic          timeout_err
);

    // Handshake: a requester raises x_start for one cycle with x_we/x_addr/x_din valid;
    // the request is held until the arbiter answers with a one-cycle x_rdy, and a strobe
    // arriving while that port already has a request held is dropped. Toward the RAM, a
    // one-cycle m_we/m_start_read is answered by m_save_rdy/m_read_rdy some cycles later.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } req_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic          grant_b, grant_b_nx;   // 1 = port B owns the current access
    logic          last_b;
    logic          pend_a, pend_b;
    req_t          hold_a, hold_b, cur;
    logic [DW-1:0] dout_a, dout_b;
    logic [TW-1:0] timer;
    logic          mem_rdy, rd_done, wd_fire, a_fin, b_fin;

    assign cur   = grant_b ? hold_b : hold_a;
    assign a_fin = (state == DONE) && !grant_b;
    assign b_fin = (state == DONE) && grant_b;

    always_comb begin
        state_nx     = state;
        grant_b_nx   = grant_b;
        m_addr       = '0;
        m_din        = '0;
        m_we         = 1'b0;
        m_start_read = 1'b0;
        mem_rdy      = 1'b0;
        rd_done      = 1'b0;
        wd_fire      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_a || pend_b) begin
                    state_nx = ISSUE;
                    if (CPU_PRIO != 0)
                        grant_b_nx = !pend_a;
                    else if (pend_a && pend_b)
                        grant_b_nx = !last_b;
                    else
                        grant_b_nx = pend_b;
                end
            end
            ISSUE: begin
                m_addr       = cur.addr;
                m_din        = cur.din;
                m_we         = cur.we;
                m_start_read = !cur.we;
                state_nx     = WAIT;
            end
            WAIT: begin
                m_addr  = cur.addr;
                m_din   = cur.din;
                mem_rdy = cur.we ? m_save_rdy : m_read_rdy;
                rd_done = mem_rdy && !cur.we;
                if (mem_rdy) begin
                    state_nx = DONE;
                end else if (timer == T_LAST) begin
                    wd_fire  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_b     <= 1'b0;
            last_b      <= 1'b1;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            hold_a      <= '0;
            hold_b      <= '0;
            dout_a      <= '0;
            dout_b      <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_nx;
            grant_b <= grant_b_nx;

            if (state == ISSUE)
                timer <= '0;
            else if (state == WAIT)
                timer <= timer + 1'b1;

            // A read that times out returns all-ones so software sees a recognisable value.
            if (rd_done || (wd_fire && !cur.we)) begin
                if (grant_b)
                    dout_b <= rd_done ? m_dout : '1;
                else
                    dout_a <= rd_done ? m_dout : '1;
            end

            if (wd_fire)
                timeout_err <= 1'b1;
            if (state == DONE)
                last_b <= grant_b;

            // A strobe in the completion cycle re-arms the port; the set wins over the clear.
            if (a_start && (!pend_a || a_fin)) begin
                pend_a <= 1'b1;
                hold_a <= '{we: a_we, addr: a_addr, din: a_din};
            end else if (a_fin) begin
                pend_a <= 1'b0;
            end

            if (b_start && (!pend_b || b_fin)) begin
                pend_b <= 1'b1;
                hold_b <= '{we: b_we, addr: b_addr, din: b_din};
            end else if (b_fin) begin
                pend_b <= 1'b0;
            end
        end
    end

    assign a_rdy  = a_fin;
    assign b_rdy  = b_fin;
    assign a_dout = dout_a;
    assign b_dout = dout_b;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a round-robin and a CPU-priority instance share
// stimulus; a RAM model answers whichever instance is under test.
module tb_bram_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_start = 1'b0, a_we = 1'b0, b_start = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;
  logic          m_read_rdy = 1'b0, m_save_rdy = 1'b0;
  logic [DW-1:0] m_dout = '0;

  logic [DW-1:0] d0_a_dout, d0_b_dout, d1_a_dout, d1_b_dout;
  logic          d0_a_rdy, d0_b_rdy, d1_a_rdy, d1_b_rdy;
  logic [AW-1:0] d0_m_addr, d1_m_addr;
  logic [DW-1:0] d0_m_din, d1_m_din;
  logic          d0_m_we, d1_m_we, d0_m_rd, d1_m_rd;
  logic          d0_busy, d1_busy, d0_terr, d1_terr;

  logic          use_prio = 1'b0;
  logic          mem_mute = 1'b0;

  logic [DW-1:0] o_a_dout, o_b_dout, o_m_din;
  logic          o_a_rdy, o_b_rdy, o_m_we, o_m_rd, o_busy, o_terr;
  logic [AW-1:0] o_m_addr;

  int total = 0;
  int bad   = 0;
  int n_we = 0, n_rd = 0, n_ardy = 0, n_brdy = 0, n_both = 0;
  logic [AW-1:0] obs_q[$];
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] ram [0:32767];
  bit            ram_v [0:32767];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  bram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8), .CPU_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_start(a_start), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d0_a_dout), .a_rdy(d0_a_rdy),
    .b_start(b_start), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d0_b_dout), .b_rdy(d0_b_rdy),
    .m_addr(d0_m_addr), .m_din(d0_m_din), .m_we(d0_m_we), .m_start_read(d0_m_rd),
    .m_read_rdy(m_read_rdy), .m_save_rdy(m_save_rdy), .m_dout(m_dout),
    .busy(d0_busy), .timeout_err(d0_terr)
  );

  bram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8), .CPU_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_start(a_start), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d1_a_dout), .a_rdy(d1_a_rdy),
    .b_start(b_start), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d1_b_dout), .b_rdy(d1_b_rdy),
    .m_addr(d1_m_addr), .m_din(d1_m_din), .m_we(d1_m_we), .m_start_read(d1_m_rd),
    .m_read_rdy(m_read_rdy), .m_save_rdy(m_save_rdy), .m_dout(m_dout),
    .busy(d1_busy), .timeout_err(d1_terr)
  );

  assign o_a_dout = use_prio ? d1_a_dout : d0_a_dout;
  assign o_b_dout = use_prio ? d1_b_dout : d0_b_dout;
  assign o_a_rdy  = use_prio ? d1_a_rdy  : d0_a_rdy;
  assign o_b_rdy  = use_prio ? d1_b_rdy  : d0_b_rdy;
  assign o_m_addr = use_prio ? d1_m_addr : d0_m_addr;
  assign o_m_din  = use_prio ? d1_m_din  : d0_m_din;
  assign o_m_we   = use_prio ? d1_m_we   : d0_m_we;
  assign o_m_rd   = use_prio ? d1_m_rd   : d0_m_rd;
  assign o_busy   = use_prio ? d1_busy   : d0_busy;
  assign o_terr   = use_prio ? d1_terr   : d0_terr;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] addr);
    if (addr == 15'h0123) return 32'hDEADBEEF;
    return {4{addr[7:0]}};
  endfunction

  // RAM model: answers one cycle after each strobe unless muted.
  initial begin
    for (int i = 0; i < 32768; i++) ram_v[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_read_rdy <= 1'b0;
        m_save_rdy <= 1'b0;
        m_dout     <= '0;
      end else begin
        m_read_rdy <= 1'b0;
        m_save_rdy <= 1'b0;
        if (!mem_mute && o_m_we) begin
          ram[o_m_addr]   = o_m_din;
          ram_v[o_m_addr] = 1'b1;
          m_save_rdy <= 1'b1;
        end
        if (!mem_mute && o_m_rd) begin
          m_dout     <= ram_v[o_m_addr] ? ram[o_m_addr] : init_word(o_m_addr);
          m_read_rdy <= 1'b1;
        end
      end
    end
  end

  // Monitor: strobe order and pulse counts, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        n_we = 0; n_rd = 0; n_ardy = 0; n_brdy = 0; n_both = 0;
        obs_q.delete();
      end else begin
        if (o_m_we) n_we++;
        if (o_m_rd) n_rd++;
        if (o_m_we && o_m_rd) n_both++;
        if (o_m_we || o_m_rd) obs_q.push_back(o_m_addr);
        if (o_a_rdy) n_ardy++;
        if (o_b_rdy) n_brdy++;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, {17'd0, obs_q[i]}, {17'd0, exp_q[i]});
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic start_a(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    a_start = 1'b1; a_we = we; a_addr = addr; a_din = din;
  endtask

  task automatic start_b(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    b_start = 1'b1; b_we = we; b_addr = addr; b_din = din;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Called in cycle 1 after the strobe; returns the cycle index of the rdy pulse.
  task automatic wait_rdy(input bit port_b, input int max, output int cyc);
    cyc = 1;
    while (!(port_b ? o_b_rdy : o_a_rdy) && cyc < max) begin
      tick();
      cyc++;
    end
    if (!(port_b ? o_b_rdy : o_a_rdy))
      check(port_b ? "b_rdy_timeout" : "a_rdy_timeout", port_b ? o_b_rdy : o_a_rdy, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;

    // reset state
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_mstrobe", {o_m_we, o_m_rd}, 0);
    check("rst_adout", o_a_dout, 0);
    check("rst_terr", o_terr, 0);
    do_reset();

    // single read with exact cycle positions
    start_a(0, 15'h0123, '0);
    step();
    for (int c = 1; c <= 5; c++) begin
      check("rd_mstart", o_m_rd, c == 2);
      check("rd_ardy", o_a_rdy, c == 4);
      if (c >= 2) check("rd_busy", o_busy, c <= 4);
      if (c == 2) check("rd_maddr", o_m_addr, 15'h0123);
      if (c == 4) check("rd_dout", o_a_dout, 32'hDEADBEEF);
      tick();
    end
    check("rd_dout_hold", o_a_dout, 32'hDEADBEEF);
    check("rd_n_rd", n_rd, 1);

    // port B write then readback
    do_reset();
    start_b(1, 15'h7FFF, 32'h0000CAFE);
    step();
    wait_rdy(1, 20, cyc);
    check("wr_lat", cyc, 4);
    tick();
    start_b(0, 15'h7FFF, '0);
    step();
    wait_rdy(1, 20, cyc);
    check("rb_dout", o_b_dout, 32'h0000CAFE);
    tick();
    check("wr_n_we", n_we, 1);
    check("wr_n_ardy", n_ardy, 0);
    check("wr_n_brdy", n_brdy, 2);
    exp_q.push_back(15'h7FFF); exp_q.push_back(15'h7FFF);
    check_order("wr_order");

    // round-robin contention, twice
    do_reset();
    start_a(0, 15'h0100, '0); start_b(0, 15'h0200, '0);
    step();
    wait_rdy(1, 40, cyc);
    check("rr_b_lat", cyc, 8);
    tick();
    start_a(0, 15'h0101, '0); start_b(0, 15'h0202, '0);
    step();
    wait_rdy(1, 40, cyc);
    tick();
    check("rr_n_ardy", n_ardy, 2);
    exp_q.push_back(15'h0100); exp_q.push_back(15'h0200);
    exp_q.push_back(15'h0101); exp_q.push_back(15'h0202);
    check_order("rr_order");

    // round-robin: B waiting while A re-arms in its DONE cycle gets the next grant
    do_reset();
    start_a(0, 15'h0300, '0);
    step();
    start_b(0, 15'h0400, '0);
    step();
    wait_rdy(0, 20, cyc);
    start_a(0, 15'h0301, '0);
    step();
    wait_rdy(1, 20, cyc);
    wait_rdy(0, 20, cyc);
    tick();
    exp_q.push_back(15'h0300); exp_q.push_back(15'h0400); exp_q.push_back(15'h0301);
    check_order("rr_fair");

    // CPU priority: B starves behind a continuous A stream
    use_prio = 1'b1;
    do_reset();
    start_a(0, 15'h0500, '0); start_b(0, 15'h0600, '0);
    step();
    for (int k = 1; k <= 3; k++) begin
      wait_rdy(0, 20, cyc);
      check("pr_b_waits", o_b_rdy, 0);
      start_a(0, 15'h0500 + 15'(k), '0);
      step();
    end
    wait_rdy(1, 40, cyc);
    tick();
    exp_q.push_back(15'h0500); exp_q.push_back(15'h0501);
    exp_q.push_back(15'h0502); exp_q.push_back(15'h0503); exp_q.push_back(15'h0600);
    check_order("pr_order");
    use_prio = 1'b0;

    // watchdog with a silent RAM
    do_reset();
    mem_mute = 1'b1;
    start_a(0, 15'h0040, '0);
    step();
    wait_rdy(0, 40, cyc);
    check("to_lat", cyc, 11);
    check("to_dout", o_a_dout, 32'hFFFFFFFF);
    check("to_err", o_terr, 1);
    mem_mute = 1'b0;
    tick();
    start_a(0, 15'h0123, '0);
    step();
    wait_rdy(0, 20, cyc);
    check("to_next_lat", cyc, 4);
    check("to_next_dout", o_a_dout, 32'hDEADBEEF);
    check("to_err_sticky", o_terr, 1);
    do_reset();
    check("to_err_cleared", o_terr, 0);

    // duplicate strobe is dropped; strobe in the rdy cycle is accepted
    start_a(0, 15'h0010, '0);
    step();
    start_a(0, 15'h0020, '0);
    step();
    wait_rdy(0, 20, cyc);
    check("dup_dout1", o_a_dout, 32'h10101010);
    start_a(0, 15'h0030, '0);
    step();
    wait_rdy(0, 20, cyc);
    check("dup_dout2", o_a_dout, 32'h30303030);
    tick();
    check("dup_n_ardy", n_ardy, 2);
    exp_q.push_back(15'h0010); exp_q.push_back(15'h0030);
    check_order("dup_order");

    // reset while waiting on a read
    do_reset();
    start_a(0, 15'h0123, '0);
    step();
    wait_rdy(0, 20, cyc);
    tick();
    mem_mute = 1'b1;
    start_a(0, 15'h0123, '0);
    step();
    tick();
    tick();
    check("mr_in_wait", o_busy, 1);
    rst = 1'b1;
    #1;
    check("mr_busy", o_busy, 0);
    check("mr_adout", o_a_dout, 0);
    check("mr_maddr", o_m_addr, 0);
    check("mr_mstrobe", {o_m_we, o_m_rd, o_a_rdy}, 0);
    tick();
    tick();
    rst = 1'b0;
    mem_mute = 1'b0;
    repeat (12) tick();
    check("mr_no_rdy", n_ardy, 0);
    start_a(0, 15'h0123, '0);
    step();
    wait_rdy(0, 20, cyc);
    check("mr_fresh_lat", cyc, 4);
    check("mr_fresh_dout", o_a_dout, 32'hDEADBEEF);
    tick();

    check("strobe_excl", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
